// File: rtl/saph_fpu_issue.sv
// Issue unit for the saph FPU interface: credit-gated request issue, tag pipeline and in-order response FIFO.
// Optional protocol checking (orphan / missing result, sticky err) is built when SAPH_FPU_ISSUE_CHK_EN is defined.
module saph_fpu_issue #(
    parameter int LATENCY   = 2,
    parameter int RES_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_mode,
    input  logic [31:0]      req_lhs,
    input  logic [31:0]      req_rhs,
    input  logic [TAG_W-1:0] req_tag,
    output logic             fpi_d_trig,
    output logic [1:0]       fpi_d_mode,
    output logic [31:0]      fpi_d_lhs,
    output logic [31:0]      fpi_d_rhs,
    input  logic             fpi_d_ready,
    input  logic             fpi_q_trig,
    input  logic [31:0]      fpi_q_res,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_res,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             err
);
    localparam int CNT_W = $clog2(RES_DEPTH + 1);
    localparam int PTR_W = $clog2(RES_DEPTH);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] fcnt_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [31:0]      mem_res_r [RES_DEPTH];
    logic [TAG_W-1:0] mem_tag_r [RES_DEPTH];
    logic             slot_v_s;
    logic [TAG_W-1:0] slot_tag_s;
    logic             push_s;
    logic             pop_s;

    // A pop in the same cycle does not free a credit: ready looks only at the registered count.
    assign req_ready  = !rst && fpi_d_ready && (cnt_r < CNT_W'(RES_DEPTH));
    assign fpi_d_trig = req_valid && req_ready;
    assign fpi_d_mode = req_mode;
    assign fpi_d_lhs  = req_lhs;
    assign fpi_d_rhs  = req_rhs;

    generate
        if (LATENCY == 0) begin : g_slot_wire
            assign slot_v_s   = fpi_d_trig;
            assign slot_tag_s = req_tag;
        end else begin : g_slot_pipe
            logic [LATENCY-1:0] pv_r;
            logic [TAG_W-1:0]   pt_r [LATENCY];

            // Tag shift register tracking ops in the responder pipeline.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pv_r <= '0;
                    for (int i = 0; i < LATENCY; i++) pt_r[i] <= '0;
                end else begin
                    pv_r[0] <= fpi_d_trig;
                    pt_r[0] <= req_tag;
                    for (int i = 1; i < LATENCY; i++) begin
                        pv_r[i] <= pv_r[i-1];
                        pt_r[i] <= pt_r[i-1];
                    end
                end
            end

            assign slot_v_s   = pv_r[LATENCY-1];
            assign slot_tag_s = pt_r[LATENCY-1];
        end
    endgenerate

    assign push_s    = fpi_q_trig && slot_v_s;
    assign rsp_valid = (fcnt_r != '0);
    assign pop_s     = rsp_valid && rsp_ready;
    assign rsp_res   = mem_res_r[rd_ptr_r];
    assign rsp_tag   = mem_tag_r[rd_ptr_r];

`ifdef SAPH_FPU_ISSUE_CHK_EN
    logic rel_r;
    logic err_r;

    // Sticky protocol error plus one-cycle credit release for a missing result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rel_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            rel_r <= slot_v_s && !fpi_q_trig;
            err_r <= err_r || (fpi_q_trig != slot_v_s);
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    // Next credit count: issue adds, pop (and a released missing result) subtracts.
    always_comb begin
        cnt_nxt_s = cnt_r;
        case ({fpi_d_trig, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
            2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
`ifdef SAPH_FPU_ISSUE_CHK_EN
        if (rel_r) begin
            cnt_nxt_s = cnt_nxt_s - CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_nxt_s;
        end
`endif
    end

    // Credit counter, FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= '0;
            fcnt_r   <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   fcnt_r <= fcnt_r + CNT_W'(1);
                2'b01:   fcnt_r <= fcnt_r - CNT_W'(1);
                default: fcnt_r <= fcnt_r;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while empty so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_res_r[wr_ptr_r] <= fpi_q_res;
            mem_tag_r[wr_ptr_r] <= slot_tag_s;
        end
    end
endmodule

// File: doc/saph_fpu_issue.md
# saph_fpu_issue

Initiator-side issue unit for the saph FPU interface (FPI). It accepts tagged operation requests from a core or shader lane and drives them into an FPI responder (add/sub/mul/div unit). It pairs each fixed-latency result with its tag and buffers results in a response FIFO with valid/ready backpressure. A credit counter guarantees that no result can ever be dropped.

## Interface
Parameters:
- `LATENCY`, 2, fixed FPI responder latency in cycles (0..8); must equal the responder's pipeline depth.
- `RES_DEPTH`, 4, response FIFO depth; power of two, 2..16.
- `TAG_W`, 4, request tag width.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_mode`  in  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- `req_lhs`, `req_rhs`  in  32  binary32 operands.
- `req_tag`  in  TAG_W  opaque tag, returned with the result.
- `fpi_d_trig`  out  1  FPI issue strobe.
- `fpi_d_mode`  out  2  FPI mode (= `req_mode`).
- `fpi_d_lhs`, `fpi_d_rhs`  out  32  FPI operands (= `req_lhs`/`req_rhs`).
- `fpi_d_ready`  in  1  FPI responder can accept.
- `fpi_q_trig`  in  1  FPI result strobe.
- `fpi_q_res`  in  32  FPI result.
- `rsp_valid`  out  1  response FIFO non-empty.
- `rsp_ready`  in  1  consumer pops the head.
- `rsp_res`  out  32  head result.
- `rsp_tag`  out  TAG_W  head tag.
- `err`  out  1  sticky protocol error (present only with `SAPH_FPU_ISSUE_CHK_EN`; otherwise tied 0).

## Operation
- Credit counter `cnt` (0..RES_DEPTH) counts in-flight ops plus FIFO entries.
  - +1 on issue, −1 on pop. Simultaneous issue and pop leaves it unchanged.
- `req_ready = !rst && fpi_d_ready && cnt < RES_DEPTH`. A pop in the same cycle does not free a credit; this is combinational from registered `cnt` only.
- `fpi_d_trig = req_valid && req_ready`. `fpi_d_mode/lhs/rhs` are combinational pass-through of the request fields.
- Tag pipeline: a LATENCY-stage shift register of {valid, tag}, loaded with {`fpi_d_trig`, `req_tag`}.
  - For LATENCY=0 the stage is a wire.
  - The output stage is the expected-result slot.
- On `fpi_q_trig` with the expected slot valid, push {`fpi_q_res`, slot tag} into the FIFO.
- On `fpi_q_trig` with the slot invalid (orphan), discard the result.
- FIFO:
  - Circular buffer with registered read/write pointers and an occupancy count.
  - `rsp_*` come from the head entry.
  - Pop on `rsp_valid && rsp_ready`.
  - Push and pop in the same cycle are legal at any occupancy, including a push into the empty FIFO.
  - Overflow is impossible by construction of the credit counter.
- Results return in issue order; there is no reordering.

## Timing
- Issue accepted in cycle N produces `fpi_q_trig` in cycle N+LATENCY. The entry is visible on `rsp_valid` in cycle N+LATENCY+1.
- Sustained throughput is 1 op/cycle while `rsp_ready` is held high and `RES_DEPTH > LATENCY+1`.
- Reset values:
  - `cnt` 0, FIFO empty, tag pipeline cleared.
  - `rsp_valid` 0, `err` 0.
  - `fpi_d_trig` 0 and `req_ready` 0 while `rst` is high.
  - `rsp_res`/`rsp_tag` are don't-care while empty.
- Reset mid-operation drops all in-flight and buffered results.
  - Late `fpi_q_trig` pulses from a responder that was not reset are orphans: they are discarded, and flagged if checking is enabled.
- `fpi_d_ready` low blocks issue only; results still drain.

## Configuration
- `SAPH_FPU_ISSUE_CHK_EN` defined adds protocol checking. `err` sets, and stays set until `rst`, when either:
  - `fpi_q_trig` arrives with the expected slot invalid (orphan), or
  - the expected slot is valid and `fpi_q_trig` is low (missing result); the slot is then discarded and its credit released in the next cycle.
- `SAPH_FPU_ISSUE_CHK_EN` undefined: no check logic, `err` tied 0. A missing result leaks a credit permanently.

## Test plan
- Issue add 0x3F800000 + 0x40000000, tag 3, LATENCY=2 -> `rsp_valid` 3 cycles after accept, `rsp_res`=0x40400000, `rsp_tag`=3.
- Back-to-back sub 0x40400000−0x3F800000 (tag 1), mul 0x40000000×0x40400000 (tag 2), div 0x3F800000/0x40800000 (tag 5) -> in-order responses 0x40000000/1, 0x40C00000/2, 0x3E800000/5.
- RES_DEPTH=4, `rsp_ready`=0, `req_valid` held -> exactly 4 accepts, then `req_ready`=0. One pop -> `req_ready`=1 the following cycle.
- `fpi_d_ready`=0 for 3 cycles with `req_valid`=1 -> no `fpi_d_trig`, `cnt` unchanged, and in-flight results still land in the FIFO.
- With `SAPH_FPU_ISSUE_CHK_EN`: inject `fpi_q_trig` with nothing in flight -> FIFO unchanged, `err`=1 next cycle and held until `rst`.
- Assert `rst` with 2 ops in flight and 2 buffered -> `rsp_valid`=0 and `err`=0 immediately (asynchronous). After release, `req_ready` follows `fpi_d_ready` and a fresh add returns correctly.
